adc_pulse_gen: RTL and testbench

Synthetic detector-pulse source producing ADC-format samples for the shaping-filter chain. On request it emits a linear-rise / exponential-decay pulse on a programmable baseline, either single-shot or as a periodic train with pile-up. In the datapath it stands in for the ADC at the input of the shaping filter, for bench and in-system self-test of filter gain, shape and pile-up handling.

---
 rtl/adc_pulse_gen_if.sv | 27 ++
 rtl/adc_pulse_gen.sv | 159 +++++++++++++++
 tb/tb_adc_pulse_gen.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pulse_gen_if.sv
// Control and sample bus of the synthetic ADC pulse source.
// The master drives the pulse requests; the slave is the pulse generator itself.
interface adc_pulse_gen_if #(
  parameter int unsigned SIZE_ADC_DATA = 12,
  parameter int unsigned CNT_W         = 16
);
  logic                     start;
  logic                     continuous;
  logic                     stop;
  logic [SIZE_ADC_DATA-1:0] amplitude;
  logic [SIZE_ADC_DATA-1:0] baseline;
  logic [CNT_W-1:0]         period;
  logic [SIZE_ADC_DATA-1:0] output_data;
  logic                     pulse_strobe;
  logic                     busy;
  logic [15:0]              pulse_count;

  modport master (
    output start, continuous, stop, amplitude, baseline, period,
    input  output_data, pulse_strobe, busy, pulse_count
  );

  modport slave (
    input  start, continuous, stop, amplitude, baseline, period,
    output output_data, pulse_strobe, busy, pulse_count
  );
endinterface

// File: rtl/adc_pulse_gen.sv
// Synthetic detector-pulse source: linear rise, exponential decay on a latched baseline,
// single-shot or periodic with pile-up onto the decaying residual.
module adc_pulse_gen #(
  parameter int unsigned SIZE_ADC_DATA = 12,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned RISE_SHIFT    = 2,
  parameter int unsigned DECAY_SHIFT   = 4
) (
  input logic            clk,
  input logic            reset,
  adc_pulse_gen_if.slave bus
);

  localparam int unsigned VW = SIZE_ADC_DATA + 1;
  localparam int unsigned KW = RISE_SHIFT + 1;
  localparam logic [KW-1:0]            KLast  = KW'(1 << RISE_SHIFT);
  localparam logic [CNT_W-1:0]         PMin   = CNT_W'((1 << RISE_SHIFT) + 1);
  localparam logic [SIZE_ADC_DATA-1:0] OutMax = '1;

  typedef enum logic [1:0] {StIdle, StRise, StDecay, StGap} state_e;

  state_e                   state_q, state_d;
  logic [VW-1:0]            v_q, v_d, vbase_q, vbase_d, step_q, step_d, v_dec;
  logic [KW-1:0]            k_q, k_d;
  logic [SIZE_ADC_DATA-1:0] amp_q, amp_d, base_q, base_d, out_q, out_d;
  logic [CNT_W-1:0]         period_q, period_d, cnt_q, cnt_d, p_eff;
  logic [15:0]              pulse_count_q, pulse_count_d;
  logic                     pend_q, pend_d, strobe_q, busy_q, restart;
  logic [VW:0]              out_sum;

  function automatic logic [VW-1:0] sat_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [VW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[VW] ? {VW{1'b1}} : s[VW-1:0];
  endfunction

  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    vbase_d       = vbase_q;
    step_d        = step_q;
    k_d           = k_q;
    amp_d         = amp_q;
    base_d        = base_q;
    period_d      = period_q;
    cnt_d         = (state_q == StIdle) ? '0 : cnt_q + 1'b1;
    pulse_count_d = pulse_count_q;
    pend_d        = 1'b0;

    // Small decay steps fall back to -1 so the tail always reaches zero.
    if ((v_q >> DECAY_SHIFT) != '0) v_dec = v_q - (v_q >> DECAY_SHIFT);
    else if (v_q != '0)             v_dec = v_q - 1'b1;
    else                            v_dec = '0;

    p_eff   = (period_q < PMin) ? PMin : period_q;
    restart = bus.continuous && ((state_q == StDecay) || (state_q == StGap)) &&
              (cnt_q == p_eff - 1'b1);

    if (bus.stop) begin
      state_d = StIdle;
      v_d     = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          v_d = '0;
          if (bus.start) begin
            amp_d         = bus.amplitude;
            base_d        = bus.baseline;
            period_d      = bus.period;
            vbase_d       = '0;
            step_d        = VW'(bus.amplitude >> RISE_SHIFT);
            k_d           = KW'(1);
            v_d           = VW'(bus.amplitude >> RISE_SHIFT);
            state_d       = StRise;
            cnt_d         = CNT_W'(1);
            pulse_count_d = pulse_count_q + 1'b1;
            pend_d        = 1'b1;
          end
        end
        StRise: begin
          k_d = k_q + 1'b1;
          if (k_d == KLast) begin
            // Land exactly on the peak regardless of the truncated step.
            v_d     = sat_add(vbase_q, {1'b0, amp_q});
            state_d = StDecay;
          end else begin
            v_d = sat_add(v_q, step_q);
          end
        end
        StDecay: begin
          v_d = v_dec;
          if (v_dec == '0) state_d = bus.continuous ? StGap : StIdle;
        end
        StGap: begin
          v_d = '0;
          if (!bus.continuous) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      // Periodic restart stacks the new pulse on the current residual.
      if (restart) begin
        amp_d         = bus.amplitude;
        vbase_d       = v_q;
        step_d        = VW'(bus.amplitude >> RISE_SHIFT);
        v_d           = sat_add(v_q, VW'(bus.amplitude >> RISE_SHIFT));
        k_d           = KW'(1);
        state_d       = StRise;
        cnt_d         = CNT_W'(1);
        pulse_count_d = pulse_count_q + 1'b1;
        pend_d        = 1'b1;
      end
    end

    out_sum = {2'b00, base_q} + {1'b0, v_q};
    out_d   = (out_sum[VW:SIZE_ADC_DATA] != '0) ? OutMax : out_sum[SIZE_ADC_DATA-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      v_q           <= '0;
      vbase_q       <= '0;
      step_q        <= '0;
      k_q           <= '0;
      amp_q         <= '0;
      base_q        <= '0;
      period_q      <= '0;
      cnt_q         <= '0;
      pulse_count_q <= '0;
      pend_q        <= 1'b0;
      strobe_q      <= 1'b0;
      busy_q        <= 1'b0;
      out_q         <= '0;
    end else begin
      state_q       <= state_d;
      v_q           <= v_d;
      vbase_q       <= vbase_d;
      step_q        <= step_d;
      k_q           <= k_d;
      amp_q         <= amp_d;
      base_q        <= base_d;
      period_q      <= period_d;
      cnt_q         <= cnt_d;
      pulse_count_q <= pulse_count_d;
      pend_q        <= pend_d;
      strobe_q      <= pend_q && !bus.stop;
      busy_q        <= (state_d != StIdle);
      out_q         <= out_d;
    end
  end

  assign bus.output_data  = out_q;
  assign bus.pulse_strobe = strobe_q;
  assign bus.busy         = busy_q;
  assign bus.pulse_count  = pulse_count_q;

endmodule

// File: tb/tb_adc_pulse_gen.sv
// Directed bench for adc_pulse_gen: per-cycle vector tables for shape and pile-up,
// hand sequences for tail, saturation, abort, async reset and count wrap.
module tb_adc_pulse_gen;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  adc_pulse_gen_if #(.SIZE_ADC_DATA(12), .CNT_W(16)) bus ();

  adc_pulse_gen #(
    .SIZE_ADC_DATA(12),
    .CNT_W        (16),
    .RISE_SHIFT   (2),
    .DECAY_SHIFT  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit start;
    bit cont;
    int amp;
    int base;
    int per;
    int exp_out;
    bit exp_strobe;
    bit exp_busy;
    int exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit s, bit c, int amp, int base, int per,
                              int eo, bit es, bit eb, int ec);
    vec_t v;
    v.start = s; v.cont = c; v.amp = amp; v.base = base; v.per = per;
    v.exp_out = eo; v.exp_strobe = es; v.exp_busy = eb; v.exp_count = ec;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      bus.start      = vecs[i].start;
      bus.continuous = vecs[i].cont;
      bus.amplitude  = 12'(vecs[i].amp);
      bus.baseline   = 12'(vecs[i].base);
      bus.period     = 16'(vecs[i].per);
      cycle();
      check($sformatf("%s[%0d].out", tag, i), int'(bus.output_data), vecs[i].exp_out);
      check($sformatf("%s[%0d].strobe", tag, i), int'(bus.pulse_strobe), int'(vecs[i].exp_strobe));
      check($sformatf("%s[%0d].busy", tag, i), int'(bus.busy), int'(vecs[i].exp_busy));
      check($sformatf("%s[%0d].count", tag, i), int'(bus.pulse_count), vecs[i].exp_count);
    end
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      cycle();
      n++;
    end
    check($sformatf("%s.busy_fall", tag), int'(bus.busy), 0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.stop       = 1'b0;
    bus.amplitude  = '0;
    bus.baseline   = '0;
    bus.period     = '0;
    #12;
    check("reset.out", int'(bus.output_data), 0);
    check("reset.strobe", int'(bus.pulse_strobe), 0);
    check("reset.busy", int'(bus.busy), 0);
    check("reset.count", int'(bus.pulse_count), 0);
    reset = 1'b1;
    cycle();

    // Shape: baseline 100, amplitude 400, single shot; start while busy at index 5.
    vecs.delete();
    vecs.push_back(mk(1, 0, 400, 100, 0,   0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 400, 100, 0, 200, 1, 1, 1));
    vecs.push_back(mk(0, 0, 400, 100, 0, 300, 0, 1, 1));
    vecs.push_back(mk(0, 0, 400, 100, 0, 400, 0, 1, 1));
    vecs.push_back(mk(0, 0, 400, 100, 0, 500, 0, 1, 1));
    vecs.push_back(mk(1, 0,  50,   7, 9, 475, 0, 1, 1));
    vecs.push_back(mk(0, 0, 400, 100, 0, 452, 0, 1, 1));
    vecs.push_back(mk(0, 0, 400, 100, 0, 430, 0, 1, 1));
    run_vecs("shape");
    wait_idle("shape");
    check("shape.last_out", int'(bus.output_data), 101);
    check("shape.count", int'(bus.pulse_count), 1);
    cycle();
    check("shape.baseline_out", int'(bus.output_data), 100);

    // Tail: amplitude 15 decays by 1 per sample after the peak.
    bus.amplitude = 12'd15;
    bus.baseline  = 12'd0;
    bus.start     = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("tail.e0.out", int'(bus.output_data), 100);
    for (int k = 1; k <= 19; k++) begin
      cycle();
      check($sformatf("tail.e%0d.out", k), int'(bus.output_data),
            (k <= 3) ? 3 * k : ((k == 4) ? 15 : 19 - k));
      check($sformatf("tail.e%0d.busy", k), int'(bus.busy), (k <= 17) ? 1 : 0);
    end

    // Saturation, then abort during decay with a simultaneous start.
    bus.amplitude = 12'd400;
    bus.baseline  = 12'd4000;
    bus.start     = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check($sformatf("sat.e%0d.out", k), int'(bus.output_data), 4095);
    end
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    cycle();
    check("abort.busy", int'(bus.busy), 0);
    check("abort.count", int'(bus.pulse_count), 3);
    check("abort.out", int'(bus.output_data), 4095);
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    cycle();
    check("abort.baseline_out", int'(bus.output_data), 4000);
    check("abort.no_restart", int'(bus.busy), 0);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    cycle();
    check("stop_start_idle.busy", int'(bus.busy), 0);
    check("stop_start_idle.count", int'(bus.pulse_count), 3);
    bus.stop  = 1'b0;
    bus.start = 1'b0;

    // Pile-up train, period 8: second pulse rides on the 330 residual.
    vecs.delete();
    vecs.push_back(mk(1, 1, 400, 0, 8, 4000, 0, 1, 4));
    vecs.push_back(mk(0, 1, 400, 0, 8,  100, 1, 1, 4));
    vecs.push_back(mk(0, 1, 400, 0, 8,  200, 0, 1, 4));
    vecs.push_back(mk(0, 1, 400, 0, 8,  300, 0, 1, 4));
    vecs.push_back(mk(0, 1, 400, 0, 8,  400, 0, 1, 4));
    vecs.push_back(mk(0, 1, 400, 0, 8,  375, 0, 1, 4));
    vecs.push_back(mk(0, 1, 400, 0, 8,  352, 0, 1, 4));
    vecs.push_back(mk(0, 1, 400, 0, 8,  330, 0, 1, 5));
    vecs.push_back(mk(0, 1, 400, 0, 8,  430, 1, 1, 5));
    vecs.push_back(mk(0, 1, 400, 0, 8,  530, 0, 1, 5));
    vecs.push_back(mk(0, 1, 400, 0, 8,  630, 0, 1, 5));
    vecs.push_back(mk(0, 0, 400, 0, 8,  730, 0, 1, 5));
    run_vecs("pileup");
    wait_idle("pileup");
    check("pileup.count", int'(bus.pulse_count), 5);

    // Period 3 clamps to the minimum; stop cancels the strobe of the third pulse.
    bus.amplitude  = 12'd400;
    bus.baseline   = 12'd0;
    bus.period     = 16'd3;
    bus.continuous = 1'b1;
    bus.start      = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check($sformatf("p3.e%0d.strobe", k), int'(bus.pulse_strobe), (k == 1 || k == 5) ? 1 : 0);
      if (k == 5) check("p3.e5.out", int'(bus.output_data), 500);
      if (k == 8) check("p3.e8.out", int'(bus.output_data), 800);
    end
    bus.stop = 1'b1;
    cycle();
    check("p3.stop.strobe", int'(bus.pulse_strobe), 0);
    check("p3.stop.busy", int'(bus.busy), 0);
    check("p3.stop.count", int'(bus.pulse_count), 8);
    bus.stop       = 1'b0;
    bus.continuous = 1'b0;
    cycle();
    check("p3.idle.out", int'(bus.output_data), 0);

    // Async reset in the middle of the rise.
    bus.baseline = 12'd100;
    bus.start    = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    check("rst.pre.strobe", int'(bus.pulse_strobe), 1);
    check("rst.pre.out", int'(bus.output_data), 200);
    #2;
    reset = 1'b0;
    #1;
    check("rst.async.out", int'(bus.output_data), 0);
    check("rst.async.strobe", int'(bus.pulse_strobe), 0);
    check("rst.async.busy", int'(bus.busy), 0);
    check("rst.async.count", int'(bus.pulse_count), 0);
    #3;
    reset     = 1'b1;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("rst.fresh.out", int'(bus.output_data), 0);
    check("rst.fresh.count", int'(bus.pulse_count), 1);
    cycle();
    check("rst.fresh.e1.out", int'(bus.output_data), 200);
    check("rst.fresh.e1.strobe", int'(bus.pulse_strobe), 1);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;

    // Count wrap from a forced 65535.
    force dut.pulse_count_q = 16'hffff;
    cycle();
    release dut.pulse_count_q;
    check("wrap.pre", int'(bus.pulse_count), 65535);
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    check("wrap.post", int'(bus.pulse_count), 0);
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
